// File: rtl/result_checker.sv
// result_checker -- end-of-test self-checker for the RV32I single-cycle CPU.
//
// Watches CPU data-memory stores for the completion sentinel (0xff on byte
// lane 0 at DONE_ADDR). It then halts the CPU, walks the answer region
// through a spare DM read port, compares every word with a golden ROM and
// latches a pass/fail verdict.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   dm_we/dm_addr/dm_wdata       snooped CPU store bus
//   chk_rd_addr / chk_rd_data    DM read port (1-cycle latency)
//   gold_idx / gold_data         golden ROM port (1-cycle latency)
//   cpu_halt, busy, done, pass, timeout, err_count   status / verdict
//   mm_valid, mm_addr, mm_got, mm_exp                per-word mismatch event
module result_checker #(
  parameter logic [31:0] ANSWER_START   = 32'h9000,
  parameter logic [31:0] DONE_ADDR      = 32'hfffc,
  parameter int          NUM_WORDS      = 64,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] chk_rd_addr,
  input  logic [31:0] chk_rd_data,
  output logic [15:0] gold_idx,
  input  logic [31:0] gold_data,
  output logic        cpu_halt,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic        mm_valid,
  output logic [31:0] mm_addr,
  output logic [31:0] mm_got,
  output logic [31:0] mm_exp
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {WATCH, SCAN, DRAIN, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] cyc_q, cyc_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic        cmp_vld_q, cmp_vld_d;     // read data this cycle belongs to an issued word
  logic [31:0] cmp_addr_q, cmp_addr_d;   // address of the word being compared
  logic        halt_q, halt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [15:0] err_q, err_d;
  logic        mm_valid_q, mm_valid_d;
  logic [31:0] mm_addr_q, mm_addr_d;
  logic [31:0] mm_got_q, mm_got_d;
  logic [31:0] mm_exp_q, mm_exp_d;

  logic trigger;
  assign trigger = dm_we[0] && (dm_addr == DONE_ADDR) && (dm_wdata[7:0] == 8'hff);

  // Only lane 0 / byte 0 of the store bus matter for the sentinel.
  logic unused_bits;
  assign unused_bits = ^{dm_we[3:1], dm_wdata[31:8]};

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    idx_d      = idx_q;
    rd_addr_d  = rd_addr_q;
    halt_d     = halt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    err_d      = err_q;
    mm_valid_d = 1'b0;
    mm_addr_d  = mm_addr_q;
    mm_got_d   = mm_got_q;
    mm_exp_d   = mm_exp_q;
    // Compare stage trails issue by one cycle; it keeps running into DRAIN.
    cmp_vld_d  = (state_q == SCAN);
    cmp_addr_d = rd_addr_q;

    if (cmp_vld_q && (chk_rd_data != gold_data)) begin
      mm_valid_d = 1'b1;
      mm_addr_d  = cmp_addr_q;
      mm_got_d   = chk_rd_data;
      mm_exp_d   = gold_data;
      if (err_q != 16'hffff) err_d = err_q + 16'd1;
    end

    unique case (state_q)
      WATCH: begin
        cyc_d = cyc_q + 32'd1;
        if (trigger) begin
          state_d   = SCAN;
          halt_d    = 1'b1;
          busy_d    = 1'b1;
          rd_addr_d = ANSWER_START;
          idx_d     = 16'd0;
        end else if (cyc_q == TO_LAST) begin
          state_d   = DONE;
          halt_d    = 1'b1;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
      end
      SCAN: begin
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          idx_d     = idx_q + 16'd1;
          rd_addr_d = rd_addr_q + 32'd4;
        end
      end
      DRAIN: begin
        // First DRAIN cycle compares the last word; the second sees its
        // effect on err_q and publishes the verdict.
        if (!cmp_vld_q) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == 16'd0);
        end
      end
      DONE: ;
      default: state_d = WATCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WATCH;
      cyc_q      <= '0;
      idx_q      <= '0;
      rd_addr_q  <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
      halt_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= '0;
      mm_valid_q <= 1'b0;
      mm_addr_q  <= '0;
      mm_got_q   <= '0;
      mm_exp_q   <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      idx_q      <= idx_d;
      rd_addr_q  <= rd_addr_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_addr_q <= cmp_addr_d;
      halt_q     <= halt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      mm_valid_q <= mm_valid_d;
      mm_addr_q  <= mm_addr_d;
      mm_got_q   <= mm_got_d;
      mm_exp_q   <= mm_exp_d;
    end
  end

  assign chk_rd_addr = rd_addr_q;
  assign gold_idx    = idx_q;
  assign cpu_halt    = halt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign err_count   = err_q;
  assign mm_valid    = mm_valid_q;
  assign mm_addr     = mm_addr_q;
  assign mm_got      = mm_got_q;
  assign mm_exp      = mm_exp_q;

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: a DM/golden memory model, randomized answer
// data and a reference model derived from the checker's timing rules
// (word i issued at T+1+i, mismatch at T+3+i, verdict at T+NW+3).
module tb_result_checker;
  localparam int NW = 64;
  localparam logic [31:0] BASE = 32'h9000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [31:0] chk_rd_addr, rd_data, gold_data, mm_addr, mm_got, mm_exp;
  logic [15:0] gold_idx, err_count;
  logic        cpu_halt, busy, done, pass, timeout, mm_valid;

  // second instance with a short timeout, never sees a sentinel
  logic [3:0]  t_we    = 4'h0;
  logic [31:0] t_addr  = 32'h0;
  logic [31:0] t_wdata = 32'h0;
  logic [31:0] t_rdata = 32'h0;
  logic [31:0] t_gdata = 32'h0;
  logic [31:0] t_rd_addr, t_mm_addr, t_mm_got, t_mm_exp;
  logic [15:0] t_gold_idx, t_err;
  logic        t_halt, t_busy, t_done, t_pass, t_timeout, t_mm_valid;

  result_checker #(.NUM_WORDS(NW)) u_dut (
    .clk(clk), .rst(rst), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .chk_rd_addr(chk_rd_addr), .chk_rd_data(rd_data), .gold_idx(gold_idx),
    .gold_data(gold_data), .cpu_halt(cpu_halt), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_count(err_count), .mm_valid(mm_valid),
    .mm_addr(mm_addr), .mm_got(mm_got), .mm_exp(mm_exp));

  result_checker #(.NUM_WORDS(NW), .TIMEOUT_CYCLES(100)) u_to (
    .clk(clk), .rst(rst), .dm_we(t_we), .dm_addr(t_addr), .dm_wdata(t_wdata),
    .chk_rd_addr(t_rd_addr), .chk_rd_data(t_rdata), .gold_idx(t_gold_idx),
    .gold_data(t_gdata), .cpu_halt(t_halt), .busy(t_busy), .done(t_done),
    .pass(t_pass), .timeout(t_timeout), .err_count(t_err), .mm_valid(t_mm_valid),
    .mm_addr(t_mm_addr), .mm_got(t_mm_got), .mm_exp(t_mm_exp));

  logic [31:0] dm_mem   [NW];
  logic [31:0] gold_mem [NW];
  logic [31:0] rd_off;
  assign rd_off = (chk_rd_addr - BASE) >> 2;

  always @(posedge clk) begin
    rd_data   <= dm_mem[rd_off[5:0]];
    gold_data <= gold_mem[gold_idx[5:0]];
  end

  int    n_vec = 0, n_err = 0, cyc = 0;
  string ctx = "";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %h want %h", ctx, tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic drive(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    dm_we = we; dm_addr = a; dm_wdata = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive(4'h0, 32'h0, 32'h0);
    tick(); tick();
    rst = 1'b0; cyc = 0;
  endtask

  task automatic fill_equal();
    for (int i = 0; i < NW; i++) begin
      dm_mem[i]   = $urandom;
      gold_mem[i] = dm_mem[i];
    end
  endtask

  task automatic corrupt(input int i);
    gold_mem[i] = dm_mem[i] ^ ($urandom | 32'h1);
  endtask

  function automatic int exp_errs();
    int n = 0;
    for (int i = 0; i < NW; i++) if (dm_mem[i] != gold_mem[i]) n++;
    return n;
  endfunction

  // Called in cycle T with the sentinel store already on the bus.
  task automatic scan_check(input string nm, input bit resentinel);
    int  ne;
    int  i;
    bit  exp_mm;
    ne  = exp_errs();
    ctx = nm;
    for (int k = 1; k <= NW + 5; k++) begin
      tick();
      if (k == 1) drive(4'h0, 32'h0, 32'h0);
      if (resentinel && k == 3) drive(4'b0001, 32'hfffc, 32'h0000_00ff);
      if (resentinel && k == 4) drive(4'h0, 32'h0, 32'h0);
      i = k - 3;
      exp_mm = (i >= 0 && i < NW) ? (dm_mem[i] != gold_mem[i]) : 1'b0;
      chk("mm_valid", mm_valid, exp_mm);
      if (exp_mm) begin
        chk("mm_addr", mm_addr, BASE + 32'(4 * i));
        chk("mm_got", mm_got, dm_mem[i]);
        chk("mm_exp", mm_exp, gold_mem[i]);
      end
      if (k <= NW) begin
        chk("rd_addr", chk_rd_addr, BASE + 32'(4 * (k - 1)));
        chk("gold_idx", 32'(gold_idx), 32'(k - 1));
      end else begin
        chk("rd_addr_hold", chk_rd_addr, BASE + 32'(4 * (NW - 1)));
      end
      chk("busy", busy, (k <= NW + 2));
      chk("done", done, (k >= NW + 3));
      chk("cpu_halt", cpu_halt, 1'b1);
      if (k >= NW + 3) begin
        chk("pass", pass, (ne == 0));
        chk("err_count", 32'(err_count), 32'(ne));
        chk("timeout", timeout, 1'b0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nmm, dly;

    // reset values
    ctx = "reset";
    rst = 1'b1; drive(4'h0, 32'h0, 32'h0);
    tick(); tick();
    chk("cpu_halt", cpu_halt, 1'b0);
    chk("busy", busy, 1'b0);
    chk("done", done, 1'b0);
    chk("pass", pass, 1'b0);
    chk("timeout", timeout, 1'b0);
    chk("err_count", 32'(err_count), 32'h0);
    chk("mm_valid", mm_valid, 1'b0);
    chk("rd_addr", chk_rd_addr, 32'h0);
    rst = 1'b0; cyc = 0;

    // all words match, sentinel at cycle 500; short-timeout instance checked on the way
    fill_equal();
    while (cyc < 500) begin
      tick();
      if (cyc == 99) begin
        ctx = "timeout@99";
        chk("t_done", t_done, 1'b0);
        chk("t_halt", t_halt, 1'b0);
      end
      if (cyc == 100) begin
        ctx = "timeout@100";
        chk("t_done", t_done, 1'b1);
        chk("t_timeout", t_timeout, 1'b1);
        chk("t_pass", t_pass, 1'b0);
        chk("t_halt", t_halt, 1'b1);
        chk("t_busy", t_busy, 1'b0);
        chk("t_rd_addr", t_rd_addr, 32'h0);
        chk("main_done", done, 1'b0);
      end
    end
    ctx = "timeout@500";
    chk("t_rd_addr", t_rd_addr, 32'h0);
    chk("t_done_sticky", t_done, 1'b1);
    drive(4'b0001, 32'hfffc, 32'h0000_00ff);
    scan_check("all_match", 1'b0);

    // single mismatch at word 5
    do_reset();
    fill_equal();
    dm_mem[5] = 32'h1; gold_mem[5] = 32'h2;
    tick();
    drive(4'b0001, 32'hfffc, 32'h0000_00ff);
    scan_check("word5", 1'b0);

    // stores that must not trigger, then a real sentinel; edge words corrupted
    do_reset();
    fill_equal();
    corrupt(0); corrupt(NW - 1);
    ctx = "no_trigger";
    drive(4'b0001, 32'hfffc, 32'h0000_00fe); tick();
    drive(4'b0010, 32'hfffc, 32'hffff_ffff); tick();
    drive(4'b0001, 32'hfff8, 32'h0000_00ff); tick();
    drive(4'h0, 32'h0, 32'h0); tick();
    chk("busy", busy, 1'b0);
    chk("cpu_halt", cpu_halt, 1'b0);
    drive(4'b0001, 32'hfffc, 32'h0000_00ff);
    scan_check("edge_words", 1'b0);

    // reset in the middle of a scan, then a full rescan
    do_reset();
    fill_equal();
    for (int j = 0; j < 4; j++) corrupt(j);
    tick();
    drive(4'b0001, 32'hfffc, 32'h0000_00ff);
    ctx = "mid_reset";
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) drive(4'h0, 32'h0, 32'h0);
    end
    chk("err_before", 32'(err_count), 32'd4);
    rst = 1'b1;
    tick();
    chk("busy", busy, 1'b0);
    chk("cpu_halt", cpu_halt, 1'b0);
    chk("err_count", 32'(err_count), 32'h0);
    chk("done", done, 1'b0);
    chk("mm_valid", mm_valid, 1'b0);
    rst = 1'b0; cyc = 0;
    tick(); tick();
    drive(4'b0001, 32'hfffc, 32'h0000_00ff);
    scan_check("after_reset", 1'b0);

    // second sentinel while halted must not restart
    do_reset();
    fill_equal();
    corrupt(10);
    tick();
    drive(4'b0001, 32'hfffc, 32'h0000_00ff);
    scan_check("resentinel", 1'b1);

    // randomized mismatch patterns and trigger delays
    for (int r = 0; r < 4; r++) begin
      do_reset();
      fill_equal();
      nmm = $urandom_range(0, 6);
      for (int j = 0; j < nmm; j++) corrupt($urandom_range(0, NW - 1));
      dly = $urandom_range(1, 30);
      repeat (dly) tick();
      drive(4'b0001, 32'hfffc, {$urandom_range(0, 255) << 8} | 32'hff);
      scan_check($sformatf("rand%0d", r), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/result_checker.md
# result_checker

Synthesizable end-of-test checker for the RV32I single-cycle CPU. It snoops CPU data-memory stores for the completion sentinel (byte 0xff written at 0xfffc). It then halts the CPU, streams the answer region out of data memory through a spare read port and compares each word against a golden ROM. It reports pass/fail, an error count and per-word mismatch events, so FPGA and emulation runs self-check without a simulator.

## Interface
- ANSWER_START, 32'h9000, byte address of answer word 0
- DONE_ADDR, 32'hfffc, word-aligned sentinel address
- NUM_WORDS, 64, answer words compared (1..65535)
- TIMEOUT_CYCLES, 100000, cycles after reset before declaring timeout
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- dm_we  in  4  CPU store byte enables, bit n = lane n
- dm_addr  in  32  CPU store word address
- dm_wdata  in  32  CPU store data
- chk_rd_addr  out  32  DM read-port byte address (word aligned)
- chk_rd_data  in  32  DM read data, 1-cycle synchronous latency
- gold_idx  out  16  golden ROM index
- gold_data  in  32  golden word, 1-cycle synchronous latency
- cpu_halt  out  1  freeze CPU (PC/regfile/DM writes)
- busy  out  1  scan in progress
- done  out  1  verdict valid, sticky until reset
- pass  out  1  valid with done: zero errors and no timeout
- timeout  out  1  sentinel never seen
- err_count  out  16  mismatching words
- mm_valid  out  1  one-cycle mismatch pulse
- mm_addr  out  32  mismatching DM address
- mm_got  out  32  DM value
- mm_exp  out  32  golden value

## Operation
- States: WATCH, SCAN, DRAIN, DONE.
- Reset: state WATCH; all outputs 0; index, cycle counter, err_count cleared.
- WATCH:
  - Cycle counter increments each cycle.
  - Trigger = dm_we[0] & dm_addr==DONE_ADDR & dm_wdata[7:0]==8'hff. Other lanes or values do not trigger.
  - On trigger: go to SCAN; cpu_halt=1 and busy=1 from the next cycle.
  - If the counter reaches TIMEOUT_CYCLES-1 with no trigger: go to DONE with timeout=1, pass=0.
  - Trigger and timeout in the same cycle: trigger wins.
- SCAN:
  - Issue one read per cycle: chk_rd_addr = ANSWER_START + 4*i and gold_idx = i for i = 0..NUM_WORDS-1.
  - After the last issue, go to DRAIN.
- Compare stage, one cycle behind issue: each returned pair is compared with 32-bit equality.
  - On mismatch: err_count += 1 (saturates at 16'hffff); mm_valid pulses with mm_addr/mm_got/mm_exp registered.
- DRAIN: compare the final word, then go to DONE.
- DONE:
  - busy=0, done=1, pass = (err_count==0 including the final compare).
  - cpu_halt stays 1, and dm_* are ignored until rst.
- Address arithmetic is 32-bit, wrapping modulo 2^32 (no error).
- chk_rd_addr and gold_idx hold their last value outside SCAN.

## Timing
- Trigger store in cycle T, sampled at its rising edge. That edge also commits the store to DM.
- Word i address/index driven in cycle T+1+i. Data returns in T+2+i.
- Mismatch for word i: mm_valid high in cycle T+3+i.
- done/pass valid from cycle T+NUM_WORDS+3. Verdict latency = NUM_WORDS+3 cycles.
- cpu_halt rises in cycle T+1. CPU stores in cycle T are honoured; later ones are blocked.
- Re-triggers during SCAN, DRAIN or DONE are ignored.
- rst mid-SCAN: the next cycle is WATCH with all outputs 0 and the scan abandoned; no partial verdict.

## Test plan
- All 64 DM words equal golden, sentinel store at cycle 500:
  - done=1 at cycle 567, pass=1, err_count=0, mm_valid never high.
  - chk_rd_addr steps 0x9000..0x90fc.
- Word 5 DM=0x0000_0001, golden=0x0000_0002:
  - one mm_valid pulse at T+8 with mm_addr=0x9014, mm_got=1, mm_exp=2.
  - err_count=1, pass=0.
- Non-trigger stores, then a valid store:
  - byte 0xfe to lane 0 at 0xfffc: no trigger.
  - byte 0xff on lane 1 only: no trigger.
  - 0xff at 0xfff8: no trigger.
  - then 0x0000_00ff with dm_we=4'b0001 at 0xfffc: triggers.
- TIMEOUT_CYCLES=100, no sentinel:
  - done=1, timeout=1, pass=0 at cycle 100 after reset release.
  - cpu_halt=1, and no reads are issued.
- Reset mid-scan: assert rst at T+10.
  - Next cycle: busy=0, cpu_halt=0, err_count=0.
  - A new sentinel then completes a full 64-word scan with the correct verdict.
- Second sentinel store in cycle T+3 (CPU halted, driven by the bench):
  - no restart; verdict timing is unchanged.
